// File: rtl/adc_pkg.sv
// adc_pkg: shared types and constants for the ADC capture sequencer.
//   state_t       : sequencer FSM states (AMP exists only with AMP_CFG_EN)
//   FRAME_LEN_DEF : default number of read cycles per conversion frame
//   AMP_CMD_W     : preamp gain command width in bits
//   AMP_SLACK     : minimum cycles left in WAIT before a gain transfer may start
// Optional feature macro: AMP_CFG_EN
package adc_pkg;
  localparam int FRAME_LEN_DEF = 34;
  localparam int AMP_CMD_W     = 8;
  localparam int AMP_SLACK     = 20;

`ifdef AMP_CFG_EN
  typedef enum logic [2:0] {IDLE, CONV, SHIFT, WAIT, AMP} state_t;
`else
  typedef enum logic [1:0] {IDLE, CONV, SHIFT, WAIT} state_t;
`endif
endpackage

// File: rtl/adc_seq_ctrl_if.sv
// adc_seq_ctrl_if: control/status bundle between front-panel logic (master)
// and the ADC sequencer (slave).
//   enable, full, drop_clr          : control inputs to the sequencer
//   ad_conv, read, busy, sample_tick: sequencer strobes/status
//   drop_cnt                        : saturating count of frames lost to full
//   gain_a/gain_b/gain_load, amp_*  : preamp programming, AMP_CFG_EN only
// Optional feature macro: AMP_CFG_EN
interface adc_seq_ctrl_if;
  logic        enable;
  logic        full;
  logic        drop_clr;
  logic        ad_conv;
  logic        read;
  logic        busy;
  logic        sample_tick;
  logic [15:0] drop_cnt;
`ifdef AMP_CFG_EN
  logic [3:0]  gain_a;
  logic [3:0]  gain_b;
  logic        gain_load;
  logic        amp_cs;
  logic        amp_sck;
  logic        amp_mosi;
`endif

  modport master (
    output enable, full, drop_clr,
    input  ad_conv, read, busy, sample_tick, drop_cnt
`ifdef AMP_CFG_EN
    , output gain_a, gain_b, gain_load,
    input  amp_cs, amp_sck, amp_mosi
`endif
  );

  modport slave (
    input  enable, full, drop_clr,
    output ad_conv, read, busy, sample_tick, drop_cnt
`ifdef AMP_CFG_EN
    , input gain_a, gain_b, gain_load,
    output amp_cs, amp_sck, amp_mosi
`endif
  );
endinterface

// File: rtl/amp_gain_loader.sv
// amp_gain_loader: SPI shifter for the analog preamp gain word.
//   start : one-cycle request; data is captured on that cycle
//   data  : command word, sent MSB-first
//   cs    : chip select, active low, idles high
//   sck   : clk/2 serial clock, idles low; 2*W cycles per transfer
//   mosi  : serial data, updated while sck is low
//   done  : one-cycle pulse, coincides with the cycle cs returns high
// Used only when AMP_CFG_EN is defined.
module amp_gain_loader import adc_pkg::*; #(
  parameter int W = AMP_CMD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data,
  output logic         cs,
  output logic         sck,
  output logic         mosi,
  output logic         done
);
  localparam int             HW     = $clog2(2*W);
  localparam logic [HW-1:0]  H_LAST = HW'(2*W-1);

  logic          active;
  logic [HW-1:0] half;
  logic [W-1:0]  sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      half   <= '0;
      sh     <= '0;
      cs     <= 1'b1;
      sck    <= 1'b0;
      mosi   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active <= 1'b1;
          half   <= '0;
          cs     <= 1'b0;
          sck    <= 1'b0;
          mosi   <= data[W-1];
          sh     <= {data[W-2:0], 1'b0};
        end
      end else begin
        half <= half + 1'b1;
        if (!half[0]) begin
          sck <= 1'b1;
        end else begin
          // falling half: either present the next bit or close the frame
          sck <= 1'b0;
          if (half == H_LAST) begin
            active <= 1'b0;
            cs     <= 1'b1;
            mosi   <= 1'b0;
            done   <= 1'b1;
          end else begin
            mosi <= sh[W-1];
            sh   <= {sh[W-2:0], 1'b0};
          end
        end
      end
    end
  end
endmodule

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: ADC capture sequencer.
//   clk, rst : system clock; asynchronous active-high reset
//   bus      : adc_seq_ctrl_if.slave (enable/full/drop_clr in,
//              ad_conv/read/busy/sample_tick/drop_cnt out, amp_* optional)
// One frame = CONV (1 cycle, ad_conv) + SHIFT (FRAME_LEN cycles, read) +
// WAIT until SAMPLE_PERIOD cycles have elapsed since CONV.
// Optional feature macro: AMP_CFG_EN (preamp gain programming over SPI,
// issued from IDLE or from WAIT when enough slack remains).
module adc_seq_ctrl import adc_pkg::*; #(
  parameter int FRAME_LEN     = FRAME_LEN_DEF,
  parameter int SAMPLE_PERIOD = 64
) (
  input logic           clk,
  input logic           rst,
  adc_seq_ctrl_if.slave bus
);
  localparam int            PW     = $clog2(SAMPLE_PERIOD);
  localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD-1);
  localparam logic [PW-1:0] F_LAST = PW'(FRAME_LEN);
  localparam logic [PW-1:0] F_PRE  = PW'(FRAME_LEN-1);

  state_t        state;
  logic [PW-1:0] pcnt;          // 0 in the CONV cycle, free-running after
  logic          ad_conv_q;
  logic          read_q;
  logic          busy_q;
  logic          tick_q;
  logic [15:0]   drop_q;

`ifdef AMP_CFG_EN
  // Last WAIT count at which a transfer still finishes before the next CONV.
  localparam logic [PW-1:0] SLACK_LIM = PW'(SAMPLE_PERIOD-1-AMP_SLACK);

  logic                 pend;
  logic [AMP_CMD_W-1:0] pend_word;
  logic [AMP_CMD_W-1:0] tx_word;
  logic                 amp_start;
  logic                 amp_done;
  state_t               ret_state;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      ad_conv_q <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
`ifdef AMP_CFG_EN
      pend      <= 1'b0;
      pend_word <= '0;
      tx_word   <= '0;
      amp_start <= 1'b0;
      ret_state <= IDLE;
`endif
    end else begin
      pcnt      <= pcnt + 1'b1;
      ad_conv_q <= 1'b0;
      tick_q    <= 1'b0;
`ifdef AMP_CFG_EN
      amp_start <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state     <= CONV;
            ad_conv_q <= 1'b1;
            busy_q    <= 1'b1;
            pcnt      <= '0;
          end
`ifdef AMP_CFG_EN
          else if (pend) begin
            state     <= AMP;
            busy_q    <= 1'b1;
            amp_start <= 1'b1;
            tx_word   <= pend_word;
            pend      <= 1'b0;
            ret_state <= IDLE;
          end
`endif
        end
        CONV: begin
          state  <= SHIFT;
          read_q <= 1'b1;
          tick_q <= (FRAME_LEN == 1);
        end
        SHIFT: begin
          if (pcnt == F_LAST) begin
            state  <= WAIT;
            read_q <= 1'b0;
          end else if (pcnt == F_PRE) begin
            tick_q <= 1'b1;
          end
        end
        WAIT: begin
          if (pcnt == P_LAST) begin
            if (bus.enable) begin
              state     <= CONV;
              ad_conv_q <= 1'b1;
              pcnt      <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
`ifdef AMP_CFG_EN
          else if (pend && pcnt <= SLACK_LIM) begin
            state     <= AMP;
            amp_start <= 1'b1;
            tx_word   <= pend_word;
            pend      <= 1'b0;
            ret_state <= WAIT;
          end
`endif
        end
`ifdef AMP_CFG_EN
        AMP: begin
          // pcnt keeps running so the sample period is unaffected
          if (amp_done) begin
            state  <= ret_state;
            busy_q <= (ret_state != IDLE);
          end
        end
`endif
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          read_q <= 1'b0;
        end
      endcase
`ifdef AMP_CFG_EN
      // a new load wins over the clear above, so it is never lost
      if (bus.gain_load) begin
        pend      <= 1'b1;
        pend_word <= {bus.gain_b, bus.gain_a};
      end
`endif
    end
  end

  // full is sampled in the CONV cycle; clear beats a coincident increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_q <= '0;
    else if (bus.drop_clr)
      drop_q <= '0;
    else if (ad_conv_q && bus.full && drop_q != 16'hFFFF)
      drop_q <= drop_q + 1'b1;
  end

  assign bus.ad_conv     = ad_conv_q;
  assign bus.read        = read_q;
  assign bus.busy        = busy_q;
  assign bus.sample_tick = tick_q;
  assign bus.drop_cnt    = drop_q;

`ifdef AMP_CFG_EN
  amp_gain_loader #(.W(AMP_CMD_W)) u_amp (
    .clk   (clk),
    .rst   (rst),
    .start (amp_start),
    .data  (tx_word),
    .cs    (bus.amp_cs),
    .sck   (bus.amp_sck),
    .mosi  (bus.amp_mosi),
    .done  (amp_done)
  );
`endif
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: scoreboard bench for adc_seq_ctrl.
// Stimulus pushes expected conversion times / drop counts (and gain words
// when AMP_CFG_EN is defined); a negedge monitor pops and compares.
module tb_adc_seq_ctrl;
  import adc_pkg::*;
  localparam int FL = 34;
  localparam int SP = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_seq_ctrl_if bus();
  adc_seq_ctrl #(.FRAME_LEN(FL), .SAMPLE_PERIOD(SP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int t; int drop; } frame_t;
  frame_t exp_q[$];
  frame_t fr;
  int     mdl_drop = 0;

`ifdef AMP_CFG_EN
  typedef struct { logic [7:0] w; int t; } amp_t;
  amp_t       amp_q[$];
  amp_t       ar;
  bit         in_xfer = 0;
  bit         prev_sck = 0;
  int         nbits = 0;
  int         cs_fall = 0;
  logic [7:0] word = '0;
`endif

  // ---------------- monitor ----------------
  int last_conv = -100;
  int rlen = 0;
  int ticks = 0;
  bit drop_pend = 0;
  int drop_exp = 0;

  always @(negedge clk) begin
    if (rst) begin
      rlen = 0; ticks = 0; drop_pend = 0;
    end else begin
      if (drop_pend) begin
        chk("drop_cnt", bus.drop_cnt, drop_exp);
        drop_pend = 0;
      end
      if (bus.ad_conv) begin
        if (exp_q.size() == 0) chk("conv_extra", cyc, -1);
        else begin
          fr = exp_q.pop_front();
          chk("conv_time", cyc, fr.t);
          drop_exp  = fr.drop;
          drop_pend = 1;
        end
        last_conv = cyc;
      end
      if (bus.read) begin
        if (rlen == 0) chk("read_start", cyc, last_conv + 1);
        rlen++;
        if (bus.sample_tick) begin
          ticks++;
          chk("tick_pos", rlen, FL);
        end
      end else begin
        if (bus.sample_tick) chk("tick_stray", bus.sample_tick, 0);
        if (rlen != 0) begin
          chk("read_len", rlen, FL);
          chk("tick_cnt", ticks, 1);
          rlen = 0; ticks = 0;
        end
      end
`ifdef AMP_CFG_EN
      if (!bus.amp_cs && !in_xfer) begin
        in_xfer = 1; nbits = 0; word = '0; cs_fall = cyc;
      end
      if (bus.amp_sck && !prev_sck) begin
        chk("amp_cs_low", bus.amp_cs, 0);
        word = {word[6:0], bus.amp_mosi};
        nbits++;
      end
      if (bus.amp_cs && in_xfer) begin
        in_xfer = 0;
        chk("amp_bits", nbits, 8);
        if (amp_q.size() == 0) chk("amp_extra", word, -1);
        else begin
          ar = amp_q.pop_front();
          chk("amp_word", word, ar.w);
          if (ar.t >= 0) chk("amp_start", cs_fall, ar.t);
        end
      end
      prev_sck = bus.amp_sck;
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Run nf frames with enable high; drop enable on read cycle 10 of the
  // last frame and check the sequencer settles to IDLE after that WAIT.
  task automatic run_frames(input int nf, input bit [3:0] full_m,
                            input bit [3:0] clr_m, input bit amp_ld);
    int c0, c;
    c0 = cyc + 1;
    bus.enable = 1'b1;
    for (int k = 0; k < nf; k++) begin
      if (clr_m[k]) mdl_drop = 0;
      else if (full_m[k] && mdl_drop != 16'hFFFF) mdl_drop++;
      exp_q.push_back('{c0 + k*SP, mdl_drop});
    end
    for (int k = 0; k < nf; k++) begin
      c = c0 + k*SP;
      wait_cyc(c);
      bus.full = full_m[k];
      bus.drop_clr = clr_m[k];
      wait_cyc(c + 1);
      bus.full = 1'b0;
      bus.drop_clr = 1'b0;
`ifdef AMP_CFG_EN
      if (amp_ld && k == 0) begin
        wait_cyc(c + 5);
        bus.gain_a = 4'h5; bus.gain_b = 4'hC; bus.gain_load = 1'b1;
        amp_q.push_back('{8'hC5, c + FL + 3});
        wait_cyc(c + 6);
        bus.gain_load = 1'b0;
      end
`endif
    end
    c = c0 + (nf-1)*SP;
    wait_cyc(c + 10);
    bus.enable = 1'b0;
    wait_cyc(c + SP - 1);
    chk("busy_wait", bus.busy, 1);
    wait_cyc(c + SP);
    chk("busy_idle", bus.busy, 0);
    wait_cyc(c + SP + 5);
    chk("conv_pending", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  int m;
  initial begin
    bus.enable = 1'b0; bus.full = 1'b0; bus.drop_clr = 1'b0;
`ifdef AMP_CFG_EN
    bus.gain_a = '0; bus.gain_b = '0; bus.gain_load = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ad_conv", bus.ad_conv, 0);
    chk("rst_read", bus.read, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tick", bus.sample_tick, 0);
    chk("rst_drop", bus.drop_cnt, 0);
`ifdef AMP_CFG_EN
    chk("rst_amp_cs", bus.amp_cs, 1);
`endif
    @(negedge clk); #2 rst = 1'b0;

    // plain pacing, then enable drop mid-frame
    run_frames(3, 4'b0000, 4'b0000, 1'b0);

    // three drops
    run_frames(3, 4'b0111, 4'b0000, 1'b0);
    chk("drop_three", bus.drop_cnt, 3);

    // saturation, then clear coinciding with a drop
    force dut.drop_q = 16'hFFFE;
    @(negedge clk);
    release dut.drop_q;
    @(negedge clk);
    chk("drop_preload", bus.drop_cnt, 16'hFFFE);
    mdl_drop = 16'hFFFE;
    run_frames(3, 4'b0111, 4'b0100, 1'b0);

    // reset mid-SHIFT
    @(negedge clk);
    m = cyc + 1;
    bus.enable = 1'b1; bus.full = 1'b1;
    mdl_drop = 1;
    exp_q.push_back('{m, 1});
    wait_cyc(m + 1);
    bus.full = 1'b0;
    wait_cyc(m + 6);
    chk("pre_rst_read", bus.read, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_read", bus.read, 0);
    chk("arst_ad_conv", bus.ad_conv, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_drop", bus.drop_cnt, 0);
`ifdef AMP_CFG_EN
    chk("arst_amp_cs", bus.amp_cs, 1);
`endif
    mdl_drop = 0;
    repeat (2) @(negedge clk);
    m = cyc + 1;
    exp_q.push_back('{m, 0});
    #2 rst = 1'b0;
    wait_cyc(m + 10);
    bus.enable = 1'b0;
    wait_cyc(m + SP + 3);
    chk("rst_run_idle", bus.busy, 0);
    chk("rst_run_pending", exp_q.size(), 0);

`ifdef AMP_CFG_EN
    // gain load from IDLE
    @(negedge clk);
    bus.gain_a = 4'h3; bus.gain_b = 4'hA; bus.gain_load = 1'b1;
    amp_q.push_back('{8'hA3, -1});
    @(negedge clk);
    bus.gain_load = 1'b0;
    repeat (40) @(negedge clk);
    chk("amp_idle_done", amp_q.size(), 0);
    // gain load during SHIFT, deferred into WAIT
    run_frames(3, 4'b0000, 4'b0000, 1'b1);
    chk("amp_shift_done", amp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_seq_ctrl.md
# adc_seq_ctrl

Sequencer for the ADC capture path. It generates the conversion strobe (`ad_conv`) and shift enable (`read`) that drive the ADC reader and the ADC serial interface, paces samples at a fixed period, and counts frames dropped because the sample FIFO is full. Optionally it programs the analog preamp gain over SPI between conversions. It sits between the front-panel/control logic and the ADC reader, in the same `clk` domain.

## Interface
- `FRAME_LEN`, 34: `read` cycles per conversion frame.
- `SAMPLE_PERIOD`, 64: cycles from one `ad_conv` to the next; must be ≥ `FRAME_LEN`+2.
- `clk` in 1: system clock; also the ADC serial clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: run continuous sampling.
- `full` in 1: sample FIFO full, sampled in the `ad_conv` cycle.
- `ad_conv` out 1: conversion strobe to ADC and reader.
- `read` out 1: reader shift enable.
- `busy` out 1: high in any state other than IDLE.
- `sample_tick` out 1: one-cycle pulse on the last `read` cycle of each frame.
- `drop_cnt` out 16: frames lost to `full`; saturating.
- `drop_clr` in 1: synchronous clear of `drop_cnt`.
- `AMP_CFG_EN` only:
  - `gain_a` in 4
  - `gain_b` in 4
  - `gain_load` in 1
  - `amp_cs` out 1
  - `amp_sck` out 1
  - `amp_mosi` out 1

## Operation
- States: IDLE, CONV, SHIFT, WAIT, plus AMP (`AMP_CFG_EN` only).
- IDLE → CONV when `enable`=1.
- CONV lasts 1 cycle with `ad_conv`=1, then → SHIFT.
- SHIFT lasts `FRAME_LEN` cycles with `read`=1. `sample_tick` pulses on the final cycle, then → WAIT.
- WAIT runs until the period counter reaches `SAMPLE_PERIOD`-1 (counted from the CONV cycle). Then:
  - → CONV if `enable`=1;
  - otherwise → IDLE.
- Deasserting `enable` mid-frame never truncates a frame; the frame completes, then IDLE.
- Drop accounting: if `full`=1 during CONV, `drop_cnt` increments, saturating at 0xFFFF.
  - If `drop_clr` and an increment coincide, the clear wins and the result is 0.
- Each `ad_conv` transfers the previous frame's data to the FIFO. The first frame after IDLE therefore delivers stale or zero data; software discards the first sample after enable.
- Reset value of every output is 0, except `amp_cs`=1. The state returns to IDLE.
- Reset asserted mid-frame aborts the frame immediately.

## Timing
- `ad_conv` is high exactly 1 cycle per period; consecutive rising edges are exactly `SAMPLE_PERIOD` cycles apart while `enable`=1.
- `read` rises the cycle after `ad_conv` and stays high for `FRAME_LEN` contiguous cycles.
- `enable` rising while IDLE produces `ad_conv` on the next cycle (1-cycle latency).
- `busy` is registered and matches the state.

## Configuration
- Macro: `AMP_CFG_EN`.
- Defined:
  - `gain_load`=1 latches `{gain_b, gain_a}` and sets a pending flag.
  - The pending load is serviced only from IDLE, or from WAIT when at least 20 cycles remain before the next CONV. Otherwise it stays pending.
  - In AMP: `amp_cs`=0, then 8 bits are shifted MSB-first with `amp_sck` = `clk`/2. `amp_mosi` changes while `amp_sck` is low.
  - Then `amp_cs`=1 for 1 cycle, and the FSM returns to the state it left, with the period counter still running.
  - A second `gain_load` during AMP overwrites the pending word; it is sent after the current transfer.
- Undefined:
  - The AMP ports and logic are absent.
  - The FSM has 4 states.

## Structure
- Package `adc_pkg`:
  - state enumeration;
  - `FRAME_LEN` default;
  - amp command width (8);
  - minimum WAIT slack constant (20).
- Sub-module `amp_gain_loader`: SPI shifter with `start`/`done` handshake, instantiated only under `AMP_CFG_EN`.

## Test plan
- Reset, then `enable`=1 with defaults:
  - `ad_conv` pulses every 64 cycles;
  - `read` is high 34 cycles starting 1 cycle after `ad_conv`;
  - `sample_tick` fires on the 34th `read` cycle.
- `enable` dropped on `read` cycle 10: the frame completes all 34 cycles, no further `ad_conv`, `busy`=0 after WAIT ends.
- `full`=1 across 3 conversions → `drop_cnt`=3. Preload near 0xFFFF and apply 2 drops → `drop_cnt` stays 0xFFFF. `drop_clr` coinciding with a drop → `drop_cnt`=0.
- `rst` asserted mid-SHIFT:
  - `read`, `ad_conv`, `busy` and `drop_cnt` go to 0 immediately;
  - `amp_cs`=1;
  - after release with `enable`=1, the first `ad_conv` appears 1 cycle later.
- `AMP_CFG_EN`, `gain_a`=4'h3, `gain_b`=4'hA, load in IDLE:
  - `amp_mosi` shows 0xA3 MSB-first over 8 `amp_sck` rising edges;
  - `amp_cs` is low throughout the transfer.
- `AMP_CFG_EN`, load issued during SHIFT:
  - the transfer is deferred to WAIT;
  - `ad_conv` spacing stays exactly 64 cycles.
